// File: rtl/ddr_host_sequencer.sv
// DDR controller user-port initiator: power-up programming, then single read/write bursts.
// Optional CMDACK watchdog is built in when DDR_HOST_CMD_TIMEOUT_EN is defined.
module ddr_host_sequencer #(
    parameter int unsigned      ASIZE       = 23,
    parameter int unsigned      DSIZE       = 128,
    parameter int unsigned      INIT_CYCLES = 20000,
    parameter logic [ASIZE-1:0] REG1_VAL    = 23'h000450,
    parameter logic [ASIZE-1:0] REG2_VAL    = 23'h000186,
    parameter logic [ASIZE-1:0] MODE_VAL    = 23'h000022,
    parameter int unsigned      BURST       = 2,
    parameter int unsigned      WR_LAT      = 3,
    parameter int unsigned      RD_LAT      = 6,
    parameter int unsigned      TIMEOUT     = 255
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               usr_valid,
    output logic               usr_ready,
    input  logic               usr_write,
    input  logic [ASIZE-1:0]   usr_addr,
    input  logic [DSIZE-1:0]   usr_wdata,
    input  logic [DSIZE/8-1:0] usr_dm,
    output logic               wdata_req,
    output logic [DSIZE-1:0]   rd_data,
    output logic               rd_valid,
    output logic               init_done,
    output logic               busy,
    output logic [2:0]         ctl_cmd,
    output logic [ASIZE-1:0]   ctl_addr,
    input  logic               ctl_cmdack,
    output logic [DSIZE-1:0]   ctl_datain,
    output logic [DSIZE/8-1:0] ctl_dm,
    input  logic [DSIZE-1:0]   ctl_dataout,
    output logic               cmd_err
);

    localparam int unsigned MW      = DSIZE / 8;
    localparam int unsigned BEAT_W  = $clog2(BURST + 1);
    localparam int unsigned LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int unsigned LAT_W   = LAT_MAX;
    localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_READA  = 3'b001;
    localparam logic [2:0] CMD_WRITEA = 3'b010;
    localparam logic [2:0] CMD_PRE    = 3'b100;
    localparam logic [2:0] CMD_MODE   = 3'b101;
    localparam logic [2:0] CMD_REG1   = 3'b110;
    localparam logic [2:0] CMD_REG2   = 3'b111;

    typedef enum logic [2:0] {
        StInitWait, StPre, StReg1, StReg2, StMode, StIdle, StIssue, StXfer
    } state_e;

    state_e             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic               wr_q, wr_d;
    logic [ASIZE-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [2:0]         ctl_cmd_q, ctl_cmd_d;
    logic [ASIZE-1:0]   ctl_addr_q, ctl_addr_d;
    logic [DSIZE-1:0]   ctl_datain_q, ctl_datain_d;
    logic [MW-1:0]      ctl_dm_q, ctl_dm_d;
    logic [DSIZE-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               usr_ready_q, usr_ready_d;
    logic               init_done_q, init_done_d;
    logic               busy_q, busy_d;

    logic               cmd_state;
    logic [2:0]         cmd_code;
    logic [ASIZE-1:0]   cmd_addr;
    state_e             cmd_next;

`ifdef DDR_HOST_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               cmd_err_q, cmd_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        ctl_cmd_d    = CMD_NOP;
        ctl_addr_d   = ctl_addr_q;
        ctl_datain_d = ctl_datain_q;
        ctl_dm_d     = {MW{1'b1}};
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        init_done_d  = init_done_q;
        wdata_req    = 1'b0;
        cmd_state    = 1'b0;
        cmd_code     = CMD_NOP;
        cmd_addr     = '0;
        cmd_next     = state_q;
`ifdef DDR_HOST_CMD_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        cmd_err_d    = cmd_err_q;
`endif

        unique case (state_q)
            StInitWait: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d    = StPre;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StPre: begin
                cmd_state = 1'b1; cmd_code = CMD_PRE;  cmd_addr = '0;       cmd_next = StReg1;
            end
            StReg1: begin
                cmd_state = 1'b1; cmd_code = CMD_REG1; cmd_addr = REG1_VAL; cmd_next = StReg2;
            end
            StReg2: begin
                cmd_state = 1'b1; cmd_code = CMD_REG2; cmd_addr = REG2_VAL; cmd_next = StMode;
            end
            StMode: begin
                cmd_state = 1'b1; cmd_code = CMD_MODE; cmd_addr = MODE_VAL; cmd_next = StIdle;
            end
            StIdle: begin
                if (usr_valid && usr_ready_q) begin
                    wr_d    = usr_write;
                    addr_d  = usr_addr;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cmd_state = 1'b1;
                cmd_code  = wr_q ? CMD_WRITEA : CMD_READA;
                cmd_addr  = addr_q;
                cmd_next  = StXfer;
            end
            StXfer: begin
                // lat_q counts cycles since the ISSUE acknowledge cycle
                if (lat_q != LAT_W'(LAT_MAX)) lat_d = lat_q + 1'b1;
                if (beat_q == BEAT_W'(BURST)) begin
                    state_d = StIdle;
                    beat_d  = '0;
                    lat_d   = '0;
                end else if (wr_q) begin
                    if (lat_q >= LAT_W'(WR_LAT - 1)) begin
                        wdata_req = 1'b1;
                        beat_d    = beat_q + 1'b1;
                    end
                end else if (lat_q >= LAT_W'(RD_LAT)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ctl_dataout;
                    beat_d     = beat_q + 1'b1;
                end
            end
            default: state_d = StInitWait;
        endcase

        if (cmd_state) begin
            if (ctl_cmdack) begin
                state_d = cmd_next;
`ifdef DDR_HOST_CMD_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (state_q == StMode) init_done_d = 1'b1;
                if (state_q == StIssue) begin
                    lat_d = LAT_W'(1);
                    // With a one-cycle write latency the first beat lands in the ack cycle
                    if (wr_q && (WR_LAT == 1)) begin
                        wdata_req = 1'b1;
                        beat_d    = BEAT_W'(1);
                    end
                end
            end else begin
`ifdef DDR_HOST_CMD_TIMEOUT_EN
                if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = init_done_q ? StIdle : StInitWait;
                    cmd_err_d = 1'b1;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d   = to_cnt_q + 1'b1;
                    ctl_cmd_d  = cmd_code;
                    ctl_addr_d = cmd_addr;
                end
`else
                ctl_cmd_d  = cmd_code;
                ctl_addr_d = cmd_addr;
`endif
            end
        end

        if (wdata_req) begin
            ctl_datain_d = usr_wdata;
            ctl_dm_d     = usr_dm;
        end

        usr_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StInitWait;
            init_cnt_q   <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            beat_q       <= '0;
            lat_q        <= '0;
            ctl_cmd_q    <= CMD_NOP;
            ctl_addr_q   <= '0;
            ctl_datain_q <= '0;
            ctl_dm_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            usr_ready_q  <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            ctl_cmd_q    <= ctl_cmd_d;
            ctl_addr_q   <= ctl_addr_d;
            ctl_datain_q <= ctl_datain_d;
            ctl_dm_q     <= ctl_dm_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            usr_ready_q  <= usr_ready_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef DDR_HOST_CMD_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_q  <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            cmd_err_q <= cmd_err_d;
        end
    end
    assign cmd_err = cmd_err_q;
`else
    assign cmd_err = 1'b0;
`endif

    assign usr_ready  = usr_ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign ctl_cmd    = ctl_cmd_q;
    assign ctl_addr   = ctl_addr_q;
    assign ctl_datain = ctl_datain_q;
    assign ctl_dm     = ctl_dm_q;

endmodule
